// File: rtl/img_writer.sv
// ============================================================================
//  Module   : img_writer
//  Purpose  : Receives A5 5A-framed pixel bytes from a UART and writes them into a frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_writer #(
   parameter int         PIX_COUNT   = 3072,
   parameter int         ADDR_W      = 12,
   parameter int         TIMEOUT_CYC = 1200000,
   parameter logic [7:0] SYNC0       = 8'hA5,
   parameter logic [7:0] SYNC1       = 8'h5A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_rdy,
   input  logic [7:0]        data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              err
);

   localparam int c_pix_w = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;
   localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(PIX_COUNT - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC2 = 2'd1,
      ST_PIX   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_n;
   logic [c_pix_w-1:0]  r_pix;
   logic [c_pix_w-1:0]  w_pix_n;
   logic [c_tmo_w-1:0]  r_tmo;
   logic [c_tmo_w-1:0]  w_tmo_n;
   logic                r_wr_en;
   logic                w_wr_en_n;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [ADDR_W-1:0]   w_wr_addr_n;
   logic [7:0]          r_wr_data;
   logic [7:0]          w_wr_data_n;
   logic                r_busy;
   logic                w_busy_n;
   logic                r_frame_done;
   logic                w_frame_done_n;
   logic                r_err;
   logic                w_err_n;
   logic                w_expire;

   // Expiry is the silent cycle that would bring the count to TIMEOUT_CYC;
   // a byte arriving in that same cycle cancels it.
   assign w_expire = ~data_rdy && (r_tmo == c_tmo_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pix        <= '0;
         r_tmo        <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= 8'd0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_pix        <= w_pix_n;
         r_tmo        <= w_tmo_n;
         r_wr_en      <= w_wr_en_n;
         r_wr_addr    <= w_wr_addr_n;
         r_wr_data    <= w_wr_data_n;
         r_busy       <= w_busy_n;
         r_frame_done <= w_frame_done_n;
         r_err        <= w_err_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_pix_n     = r_pix;
      w_tmo_n     = r_tmo;
      w_wr_en_n   = 1'b0;
      w_wr_addr_n = r_wr_addr;
      w_wr_data_n = r_wr_data;
      w_err_n     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_tmo_n = '0;
            if (data_rdy && (data == SYNC0)) begin
               w_state_n = ST_SYNC2;
            end
         end

         ST_SYNC2: begin
            if (data_rdy) begin
               w_tmo_n = '0;
               if (data == SYNC1) begin
                  w_state_n = ST_PIX;
                  w_pix_n   = '0;
               end else if (data != SYNC0) begin
                  w_state_n = ST_IDLE;
               end
            end else if (w_expire) begin
               w_state_n = ST_IDLE;
               w_tmo_n   = '0;
               w_err_n   = 1'b1;
            end else begin
               w_tmo_n = r_tmo + 1'b1;
            end
         end

         ST_PIX: begin
            if (data_rdy) begin
               w_tmo_n     = '0;
               w_wr_en_n   = 1'b1;
               w_wr_addr_n = ADDR_W'(r_pix);
               w_wr_data_n = data;
               // Counter parks on the last index so it never wraps inside a frame.
               if (r_pix == c_pix_last) begin
                  w_state_n = ST_DONE;
               end else begin
                  w_pix_n = r_pix + 1'b1;
               end
            end else if (w_expire) begin
               w_state_n = ST_IDLE;
               w_tmo_n   = '0;
               w_err_n   = 1'b1;
            end else begin
               w_tmo_n = r_tmo + 1'b1;
            end
         end

         ST_DONE: begin
            w_tmo_n   = '0;
            w_state_n = ST_IDLE;
         end

         default: begin
            w_state_n = ST_IDLE;
            w_tmo_n   = '0;
         end
      endcase

      w_busy_n       = (w_state_n == ST_SYNC2) || (w_state_n == ST_PIX);
      // Registered from DONE so the pulse lands one cycle after the last write.
      w_frame_done_n = (r_state == ST_DONE);
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_img_writer.sv
// ============================================================================
//  Module   : tb_img_writer
//  Purpose  : Scoreboard bench for img_writer with directed byte streams.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_writer;

   localparam int PIX_COUNT = 4;
   localparam int ADDR_W    = 4;
   localparam int TMO       = 100;

   localparam int K_WR   = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              data_rdy;
   logic [7:0]        data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              frame_done;
   logic              err;

   img_writer #(
      .PIX_COUNT   (PIX_COUNT),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TMO),
      .SYNC0       (8'hA5),
      .SYNC1       (8'h5A)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_rdy   (data_rdy),
      .data       (data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int last_c = 0;

   typedef struct {
      int                kind;
      int                c;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        d;
   } exp_t;

   exp_t exp_q[$];

   task automatic push(input int kind, input int c, input logic [ADDR_W-1:0] a, input logic [7:0] d);
      exp_t e;
      e.kind = kind;
      e.c    = c;
      e.addr = a;
      e.d    = d;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon(input int kind);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d at cyc %0d addr %0h data %0h, expected none",
                  kind, cyc, wr_addr, wr_data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.c != cyc ||
             (kind == K_WR && (e.addr !== wr_addr || e.d !== wr_data))) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d addr %0h data %0h, expected kind %0d cyc %0d addr %0h data %0h",
                     kind, cyc, wr_addr, wr_data, e.kind, e.c, e.addr, e.d);
         end
      end
   endtask

   always @(negedge clk) begin
      if (wr_en === 1'b1)      mon(K_WR);
      if (frame_done === 1'b1) mon(K_DONE);
      if (err === 1'b1)        mon(K_ERR);
   end

   // Drive one byte for one cycle; optionally register the expected write.
   task automatic send(input logic [7:0] b, input bit wr, input logic [ADDR_W-1:0] a);
      data_rdy = 1'b1;
      data     = b;
      last_c   = cyc;
      if (wr) push(K_WR, cyc + 1, a, b);
      @(posedge clk);
      #1;
      data_rdy = 1'b0;
   endtask

   task automatic hdr();
      send(8'hA5, 1'b0, '0);
      send(8'h5A, 1'b0, '0);
   endtask

   task automatic last_pix(input logic [7:0] b, input logic [ADDR_W-1:0] a);
      send(b, 1'b1, a);
      push(K_DONE, last_c + 2, '0, 8'h00);
   endtask

   task automatic idle(input int n);
      data_rdy = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_wr_en"},   {31'd0, wr_en}, 32'd0);
      chk({name, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
      chk({name, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      chk({name, "_busy"},    {31'd0, busy}, 32'd0);
      chk({name, "_done"},    {31'd0, frame_done}, 32'd0);
      chk({name, "_err"},     {31'd0, err}, 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      data_rdy = 1'b0;
      data     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      idle(2);

      // Basic frame
      hdr();
      chk("busy_after_hdr", {31'd0, busy}, 32'd1);
      send(8'h11, 1'b1, 4'd0);
      send(8'h22, 1'b1, 4'd1);
      send(8'h33, 1'b1, 4'd2);
      last_pix(8'h44, 4'd3);
      idle(3);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      chk("hold_addr", {28'd0, wr_addr}, 32'h3);
      chk("hold_data", {24'd0, wr_data}, 32'h44);

      // Repeated SYNC0 in the header
      send(8'hA5, 1'b0, '0);
      hdr();
      send(8'h01, 1'b1, 4'd0);
      send(8'h02, 1'b1, 4'd1);
      send(8'h03, 1'b1, 4'd2);
      last_pix(8'h04, 4'd3);
      idle(3);

      // Broken header: nothing written
      send(8'hA5, 1'b0, '0);
      send(8'h00, 1'b0, '0);
      send(8'h5A, 1'b0, '0);
      send(8'h11, 1'b0, '0);
      send(8'h22, 1'b0, '0);
      idle(3);
      chk("busy_bad_hdr", {31'd0, busy}, 32'd0);

      // Timeout mid-frame
      hdr();
      send(8'h10, 1'b1, 4'd0);
      send(8'h20, 1'b1, 4'd1);
      push(K_ERR, last_c + 101, '0, 8'h00);
      idle(99);
      chk("busy_before_tmo", {31'd0, busy}, 32'd1);
      idle(1);
      chk("busy_after_tmo", {31'd0, busy}, 32'd0);
      idle(2);
      hdr();
      send(8'h01, 1'b1, 4'd0);
      send(8'h02, 1'b1, 4'd1);
      send(8'h03, 1'b1, 4'd2);
      last_pix(8'h04, 4'd3);
      idle(3);

      // Byte exactly on the expiry cycle wins
      hdr();
      send(8'hAA, 1'b1, 4'd0);
      idle(99);
      send(8'hBB, 1'b1, 4'd1);
      idle(99);
      send(8'hCC, 1'b1, 4'd2);
      last_pix(8'hDD, 4'd3);
      idle(3);

      // Timeout while waiting for SYNC1
      send(8'hA5, 1'b0, '0);
      push(K_ERR, last_c + 101, '0, 8'h00);
      idle(100);
      chk("busy_sync2_tmo", {31'd0, busy}, 32'd0);
      idle(2);

      // Reset mid-frame
      hdr();
      send(8'h01, 1'b1, 4'd0);
      send(8'h02, 1'b1, 4'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all_zero("rst_mid");
      send(8'h5A, 1'b0, '0);
      send(8'h03, 1'b0, '0);
      send(8'h04, 1'b0, '0);
      idle(2);

      // Reset wins over a simultaneous SYNC0
      rst      = 1'b1;
      data_rdy = 1'b1;
      data     = 8'hA5;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      data_rdy = 1'b0;
      send(8'h5A, 1'b0, '0);
      send(8'h55, 1'b0, '0);
      send(8'h66, 1'b0, '0);
      idle(2);
      chk("busy_rst_prio", {31'd0, busy}, 32'd0);

      // Sync values as pixel data
      hdr();
      send(8'hA5, 1'b1, 4'd0);
      send(8'h5A, 1'b1, 4'd1);
      send(8'hA5, 1'b1, 4'd2);
      last_pix(8'h5A, 4'd3);
      idle(5);

      chk("pending_expected", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/img_writer.md
IMG_WRITER -- requirements
Module: img_writer

Interface
REQ-001 SHALL have parameter PIX_COUNT, default 3072, meaning pixel bytes per frame (one byte per pixel).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning frame-buffer address width; PIX_COUNT <= 2^ADDR_W.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1200000, meaning max clk cycles allowed between bytes inside a frame (100 ms at 12 MHz).
REQ-004 SHALL have parameter SYNC0, default 8'hA5, meaning first header byte.
REQ-005 SHALL have parameter SYNC1, default 8'h5A, meaning second header byte.
REQ-006 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port data_rdy  input  1  byte-valid strobe from UART receiver; each high cycle is one byte.
REQ-009 SHALL have port data  input  8  received byte, valid when data_rdy=1.
REQ-010 SHALL have port wr_en  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 SHALL have port wr_addr  output  ADDR_W  frame-buffer write address.
REQ-012 SHALL have port wr_data  output  8  frame-buffer write data.
REQ-013 SHALL have port busy  output  1  high in states SYNC2 and PIX.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of a frame is written.
REQ-015 SHALL have port err  output  1  one-cycle pulse on inter-byte timeout abort.

Function
REQ-016 SHALL implement FSM states IDLE, SYNC2, PIX, DONE; all outputs registered.
REQ-017 IDLE: data_rdy with data==SYNC0 -> SYNC2; any other byte ignored, stay IDLE.
REQ-018 SYNC2: data==SYNC1 -> PIX with pixel counter cleared to 0; data==SYNC0 -> stay SYNC2; any other byte -> IDLE, no err.
REQ-019 PIX: each data_rdy SHALL produce wr_en=1 on the next cycle with wr_addr=pixel counter value and wr_data=that byte; counter then increments by 1.
REQ-020 PIX: the byte with counter==PIX_COUNT-1 SHALL be written and FSM SHALL go to DONE; counter SHALL never exceed PIX_COUNT-1 (no wrap within a frame).
REQ-021 DONE: frame_done=1 for exactly one cycle, then IDLE; data_rdy in DONE ignored.
REQ-022 Write latency SHALL be exactly 1 cycle from data_rdy to wr_en; frame_done SHALL assert the cycle after the last wr_en.
REQ-023 Sync bytes SHALL NOT generate wr_en; pixel bytes equal to SYNC0/SYNC1 SHALL be written as ordinary data.
REQ-024 Timeout counter SHALL clear on every data_rdy and on entry to SYNC2, and count each cycle in SYNC2/PIX without data_rdy.
REQ-025 Timeout counter reaching TIMEOUT_CYC SHALL force IDLE and pulse err for one cycle; partial frame stays in buffer, no frame_done.
REQ-026 data_rdy in the same cycle as timeout expiry SHALL win: byte processed, counter cleared, no err.
REQ-027 wr_addr and wr_data SHALL hold last value when wr_en=0.
REQ-028 Counter widths SHALL hold PIX_COUNT-1 and TIMEOUT_CYC without overflow.

Reset
REQ-029 rst=1 SHALL set state IDLE, pixel and timeout counters 0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0 on the next edge.
REQ-030 rst mid-frame SHALL abandon the frame with no frame_done and no err; next frame requires full header.
REQ-031 rst SHALL take priority over data_rdy in the same cycle.

Verification (PIX_COUNT=4, TIMEOUT_CYC=100 unless noted)
REQ-032 Bytes A5,5A,11,22,33,44 -> wr_en x4, addr 0..3, data 11,22,33,44, each 1 cycle after data_rdy; frame_done one cycle after addr 3; busy low afterwards.
REQ-033 Bytes A5,A5,5A,01,02,03,04 -> frame accepted, writes 01..04 at 0..3; bytes A5,00,5A,... -> no writes, idle.
REQ-034 A5,5A,10,20 then 100 idle cycles -> err pulse once, busy=0, no frame_done; later full frame writes from addr 0.
REQ-035 Byte arriving exactly on cycle 100 of silence -> written, no err.
REQ-036 rst asserted after 2 pixels -> all outputs 0 next cycle, subsequent 5A/pixel bytes ignored until new A5,5A.
REQ-037 Pixel data A5,5A,A5,5A after header -> all four written as data, frame_done once.
